byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Parallel-to-serial transmitter: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- Serves as the transmit end of the team's bit-serial link. Its bit_out/bit_valid feed the byte deserializer's bit input directly.
- A one-word holding register lets consecutive words stream with no idle cycle between them.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = shift MSB first (link default), 0 = LSB first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_in  in  WIDTH  word to transmit.
- load  in  1  data_in valid; word accepted on the clk edge where load && ready.
- ready  out  1  word can be accepted this cycle.
- flush  in  1  synchronous abort of all buffered and in-flight data.
- bit_out  out  1  serial data bit.
- bit_valid  out  1  bit_out carries a data bit this cycle.
- frame_start  out  1  high while bit_out is the first bit of a word.
- frame_last  out  1  high while bit_out is the last bit of a word.

Behaviour:
- Reset (rst_n=0 at edge):
  - shifter, hold register and bit counter cleared; hold_valid=0; state=IDLE.
  - bit_out=0, bit_valid=0, frame_start=0, frame_last=0.
- Ready: ready = rst_n && !flush && !hold_valid (combinational). ready=1 in the first cycle after reset is released.
- States:
  - IDLE: shifter empty, bit_valid=0.
  - SHIFT: shifter holds the active word, bit_valid=1.
- IDLE, accepted load at edge k:
  - shifter <= data_in, cnt <= 0, state -> SHIFT.
  - First bit is on bit_out in the cycle after edge k, i.e. 1 cycle latency; frame_start=1 in that cycle.
- SHIFT, each edge: shifter shifts by one toward the output end, cnt increments.
  - bit_out = shifter[WIDTH-1] if MSB_FIRST, else shifter[0].
  - Registered (all outputs): frame_start=1 when cnt==0; frame_last=1 when cnt==WIDTH-1.
- SHIFT with hold empty and cnt<WIDTH-1: an accepted load writes the hold register, hold_valid<=1, ready drops next cycle.
- End of word (SHIFT, cnt==WIDTH-1), at that edge:
  - hold_valid=1: hold -> shifter, hold_valid<=0, cnt<=0, stay SHIFT (no gap).
  - hold empty and load accepted: data_in -> shifter directly, stay SHIFT (no gap).
  - Otherwise -> IDLE; bit_valid=0 next cycle.
- Flush (rst_n=1, flush=1 at edge):
  - Shifter, hold and cnt cleared; hold_valid=0; state=IDLE; all outputs 0 next cycle.
  - A load in the same cycle is not accepted (ready=0).
  - Partial word is dropped and never retransmitted.
- Priority: reset > flush > load/shift.
- Reset asserted mid-word: same effect as flush; no residual bits appear after release.
- data_in is sampled only on the accept edge; changes at other times have no effect.
- Throughput: one bit per cycle sustained; a WIDTH-bit word occupies exactly WIDTH bit_valid cycles.

Decomposition:
- Package ser_pkg:
  - default WIDTH constant;
  - state enum {IDLE, SHIFT};
  - counter width localparam $clog2(WIDTH).
- Sub-module ser_shift_reg: parallel load, one-bit shift, direction from MSB_FIRST, output tap.
- Top byte_serializer: FSM, counter, hold register, handshake.

Test Plan:
- Reset, then load 8'hA5 in IDLE -> from next cycle bit_out = 1,0,1,0,0,1,0,1 with bit_valid=1 for 8 cycles; frame_start on the first bit, frame_last on the eighth; bit_valid=0 afterwards.
- Load 8'hA5, then 8'h3C two cycles later -> ready=0 while the hold register is full; 16 contiguous valid bits 10100101 00111100 with no gap; frame_start at bits 1 and 9.
- Load 8'hFF, assert flush on the 4th bit -> bit_valid=0 the next cycle, ready=1 once flush is low; a following 8'h81 transmits cleanly as 10000001.
- rst_n low for 1 cycle during the 6th bit of 8'h5A, with a word pending in hold -> all outputs 0; no stale bits after release; ready=1.
- MSB_FIRST=0, load 8'h01 -> bit_out = 1,0,0,0,0,0,0,0.
- Loopback to the deserializer: stream 8'hC3, 8'h5A, 8'h0F back-to-back -> the deserializer outputs the same three bytes in order.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the bit-serial link transmitter.
package ser_pkg;

    localparam int SER_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit counter width; never narrower than one bit so WIDTH=2 still works.
    function automatic int ser_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int SER_DEFAULT_CNT_W = ser_cnt_width(SER_DEFAULT_WIDTH);

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register; zero-fills behind the outgoing bit so an emptied
// register reads as all zeros.
module ser_shift_reg
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             tap
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            if (MSB_FIRST) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
            end else begin
                sr <= {1'b0, sr[WIDTH-1:1]};
            end
        end
    end

    assign tap = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter with a one-word holding register so that
// back-to-back words stream without an idle bit between them.
module byte_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    input  logic             flush,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int            CW   = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state, nxt_state;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic             accept;

    logic             sr_load;
    logic             sr_shift;
    logic             sr_clear;
    logic [WIDTH-1:0] sr_din;
    logic             hold_wr;
    logic             hold_rd;

    assign ready  = rst_n && !flush && !hold_valid;
    assign accept = load && ready;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_clear  = 1'b0;
        sr_din    = data_in;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sr_load   = 1'b1;
                    nxt_cnt   = '0;
                    nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    sr_shift = 1'b1;
                    nxt_cnt  = cnt + CW'(1);
                    hold_wr  = accept;
                end else if (hold_valid) begin
                    // End of word: pending word takes over with no gap.
                    sr_load = 1'b1;
                    sr_din  = hold;
                    hold_rd = 1'b1;
                    nxt_cnt = '0;
                end else if (accept) begin
                    sr_load = 1'b1;
                    nxt_cnt = '0;
                end else begin
                    sr_clear  = 1'b1;
                    nxt_cnt   = '0;
                    nxt_state = IDLE;
                end
            end
            default: begin
                sr_clear  = 1'b1;
                nxt_cnt   = '0;
                nxt_state = IDLE;
            end
        endcase
    end

    // Reset and flush share one abort path; reset also gates ready.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            if (hold_wr) begin
                hold       <= data_in;
                hold_valid <= 1'b1;
            end else if (hold_rd) begin
                hold       <= '0;
                hold_valid <= 1'b0;
            end
            bit_valid   <= (nxt_state == SHIFT);
            frame_start <= (nxt_state == SHIFT) && (nxt_cnt == '0);
            frame_last  <= (nxt_state == SHIFT) && (nxt_cnt == LAST);
        end
    end

    ser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush || sr_clear),
        .load  (sr_load),
        .shift (sr_shift),
        .din   (sr_din),
        .tap   (bit_out)
    );

endmodule

// File: tb/tb_byte_serializer.sv
// Scoreboard bench for byte_serializer: MSB-first and LSB-first instances.
module tb_byte_serializer;

    typedef struct packed {
        logic b;
        logic fs;
        logic fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load0, flush0, load1, flush1;
    logic [7:0] din0, din1;
    logic       ready0, bo0, bv0, fs0, fl0;
    logic       ready1, bo1, bv1, fs1, fl1;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .data_in(din0), .load(load0), .ready(ready0),
        .flush(flush0), .bit_out(bo0), .bit_valid(bv0), .frame_start(fs0),
        .frame_last(fl0)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .data_in(din1), .load(load1), .ready(ready1),
        .flush(flush1), .bit_out(bo1), .bit_valid(bv1), .frame_start(fs1),
        .frame_last(fl1)
    );

    function automatic void push_word(input int which, input logic [7:0] w, input bit msb);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b  = msb ? w[7-i] : w[i];
            e.fs = (i == 0);
            e.fl = (i == 7);
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; load0 = 1'b0; flush0 = 1'b0; din0 = '0;
        load1 = 1'b0; flush1 = 1'b0; din1 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bo0, bv0, fs0, fl0} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs_msb: got %b, want 0000", {bo0, bv0, fs0, fl0});
        end
        n_checks++;
        if ({bo1, bv1, fs1, fl1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs_lsb: got %b, want 0000", {bo1, bv1, fs1, fl1});
        end
        n_checks++;
        if (ready0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b, want 0", ready0);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (ready0 !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_release: got %b, want 1", ready0);
        end
        n_checks++;
        if (ready1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_release_lsb: got %b, want 1", ready1);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   vcnt  = 0;
        int   first = -1;
        @(negedge clk);
        push_word(0, 8'hA5, 1'b1);
        din0 = 8'hA5; load0 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bv0) begin
                vcnt++;
                if (first < 0) first = c;
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL single_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL single_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
            end
            load0 = 1'b0; din0 = 8'($urandom);
        end
        n_checks++;
        if (vcnt != 8 || first != 1) begin
            n_fail++; $display("FAIL single_span: got %0d bits from cycle %0d, want 8 from cycle 1", vcnt, first);
        end
        n_checks++;
        if (bv0 !== 1'b0 || q0.size() != 0) begin
            n_fail++; $display("FAIL single_tail: got bit_valid=%b pending=%0d, want 0 and 0", bv0, q0.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   vcnt  = 0;
        int   first = -1;
        int   last  = -1;
        logic exp_ready;
        @(negedge clk);
        push_word(0, 8'hA5, 1'b1);
        din0 = 8'hA5; load0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_ready = !(c >= 3 && c <= 8);
            if (c <= 10) begin
                n_checks++;
                if (ready0 !== exp_ready) begin
                    n_fail++; $display("FAIL b2b_ready: cycle %0d got %b, want %b", c, ready0, exp_ready);
                end
            end
            if (bv0) begin
                vcnt++;
                if (first < 0) first = c;
                last = c;
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL b2b_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
            end
            if (c == 2) begin
                push_word(0, 8'h3C, 1'b1);
                din0 = 8'h3C; load0 = 1'b1;
            end else begin
                load0 = 1'b0; din0 = 8'($urandom);
            end
        end
        n_checks++;
        if (vcnt != 16 || first != 1 || last != 16) begin
            n_fail++; $display("FAIL b2b_contiguous: got %0d bits span %0d..%0d, want 16 span 1..16", vcnt, first, last);
        end
    endtask

    task automatic test_direct();
        exp_t e;
        int   vcnt  = 0;
        int   first = -1;
        int   last  = -1;
        @(negedge clk);
        push_word(0, 8'h11, 1'b1);
        din0 = 8'h11; load0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bv0) begin
                vcnt++;
                if (first < 0) first = c;
                last = c;
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL direct_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL direct_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
            end
            if (c == 8) begin
                n_checks++;
                if (ready0 !== 1'b1) begin
                    n_fail++; $display("FAIL direct_ready_last_bit: got %b, want 1", ready0);
                end
                push_word(0, 8'h22, 1'b1);
                din0 = 8'h22; load0 = 1'b1;
            end else begin
                load0 = 1'b0; din0 = 8'($urandom);
            end
        end
        n_checks++;
        if (vcnt != 16 || first != 1 || last != 16) begin
            n_fail++; $display("FAIL direct_contiguous: got %0d bits span %0d..%0d, want 16 span 1..16", vcnt, first, last);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        @(negedge clk);
        push_word(0, 8'hFF, 1'b1);
        din0 = 8'hFF; load0 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bv0) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL flush_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL flush_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
            end
            if (c == 4) begin
                flush0 = 1'b1; din0 = 8'h81; load0 = 1'b1;
                q0.delete();
                #1;
                n_checks++;
                if (ready0 !== 1'b0) begin
                    n_fail++; $display("FAIL flush_ready_during: got %b, want 0", ready0);
                end
            end else if (c == 5) begin
                n_checks++;
                if ({bo0, bv0, fs0, fl0} !== 4'b0000) begin
                    n_fail++; $display("FAIL flush_outputs: got %b, want 0000", {bo0, bv0, fs0, fl0});
                end
                flush0 = 1'b0;
                #1;
                n_checks++;
                if (ready0 !== 1'b1) begin
                    n_fail++; $display("FAIL flush_ready_after: got %b, want 1", ready0);
                end
                push_word(0, 8'h81, 1'b1);
                din0 = 8'h81; load0 = 1'b1;
            end else begin
                load0 = 1'b0; din0 = 8'($urandom);
            end
        end
        n_checks++;
        if (bv0 !== 1'b0 || q0.size() != 0) begin
            n_fail++; $display("FAIL flush_tail: got bit_valid=%b pending=%0d, want 0 and 0", bv0, q0.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        push_word(0, 8'h5A, 1'b1);
        din0 = 8'h5A; load0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bv0) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL rstmid_stale_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL rstmid_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
            end
            load0 = 1'b0; din0 = 8'($urandom);
            if (c == 2) begin
                din0 = 8'hE7; load0 = 1'b1;
            end else if (c == 6) begin
                rst_n = 1'b0;
                q0.delete();
            end else if (c == 7) begin
                n_checks++;
                if ({bo0, bv0, fs0, fl0, ready0} !== 5'b00000) begin
                    n_fail++; $display("FAIL rstmid_outputs: got %b, want 00000", {bo0, bv0, fs0, fl0, ready0});
                end
                rst_n = 1'b1;
                #1;
                n_checks++;
                if (ready0 !== 1'b1) begin
                    n_fail++; $display("FAIL rstmid_ready: got %b, want 1", ready0);
                end
            end
        end
    endtask

    task automatic test_lsb_first();
        exp_t e;
        int   vcnt = 0;
        @(negedge clk);
        push_word(1, 8'h01, 1'b0);
        din1 = 8'h01; load1 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bv1) begin
                vcnt++;
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++; $display("FAIL lsb_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q1.pop_front();
                    if ({bo1, fs1, fl1} !== e) begin
                        n_fail++; $display("FAIL lsb_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo1, fs1, fl1}, e);
                    end
                end
            end
            load1 = 1'b0; din1 = 8'($urandom);
        end
        n_checks++;
        if (vcnt != 8) begin
            n_fail++; $display("FAIL lsb_count: got %0d bits, want 8", vcnt);
        end
    endtask

    task automatic test_loopback();
        exp_t       e;
        logic [7:0] words[3];
        logic [7:0] sent[$];
        logic [7:0] acc = '0;
        logic [7:0] want;
        int         idx  = 0;
        int         nrx  = 0;
        int         vcnt = 0;
        words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h0F;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (bv0) begin
                vcnt++;
                acc = {acc[6:0], bo0};
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL loop_extra_bit: bit_valid=1 at cycle %0d, want 0", c);
                end else begin
                    e = q0.pop_front();
                    if ({bo0, fs0, fl0} !== e) begin
                        n_fail++; $display("FAIL loop_bit: cycle %0d got bit/start/last=%b, want %b", c, {bo0, fs0, fl0}, e);
                    end
                end
                if (fl0) begin
                    nrx++;
                    want = (sent.size() != 0) ? sent.pop_front() : 8'hxx;
                    n_checks++;
                    if (acc !== want) begin
                        n_fail++; $display("FAIL loop_byte: word %0d got %h, want %h", nrx, acc, want);
                    end
                end
            end
            if (idx < 3 && ready0) begin
                din0 = words[idx]; load0 = 1'b1;
                push_word(0, words[idx], 1'b1);
                sent.push_back(words[idx]);
                idx++;
            end else begin
                load0 = 1'b0; din0 = 8'($urandom);
            end
        end
        n_checks++;
        if (nrx != 3 || vcnt != 24) begin
            n_fail++; $display("FAIL loop_count: got %0d words %0d bits, want 3 words 24 bits", nrx, vcnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_direct();
        test_flush();
        test_reset_mid();
        test_lsb_first();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
